// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, talks to instruction memory with at most one
// request in flight, and buffers returned words in a small queue whose head
// feeds the F/D register. Redirects from Execute flush the queue and mark any
// in-flight fetch as wrong-path so its response is discarded.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  validF,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] PCounterF,
  output logic [DATA_WIDTH-1:0] PCPlus4F
);

  localparam int              PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0]     QCAP = (PW + 1)'(QDEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] fpc;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  outstanding;
  logic                  kill;

  logic [DATA_WIDTH-1:0] q_pc   [QDEPTH];
  logic [DATA_WIDTH-1:0] q_word [QDEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;

  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Request/response/queue handshakes; a redirect suppresses everything but the flush.
  always_comb begin
    imem_req  = rst_n && !PCSrcE && !outstanding && (count < QCAP);
    imem_addr = fpc;
    accept    = imem_req && imem_ready;
    resp      = imem_rvalid && outstanding;
    push      = resp && !kill && !PCSrcE;
    validF    = (count != '0);
    pop       = validF && !stallF && !PCSrcE;
  end

  // Head of queue presented straight to the F/D register; NOP bubble when empty.
  always_comb begin
    instr     = NOP;
    PCounterF = '0;
    if (validF) begin
      instr     = q_word[rd_ptr];
      PCounterF = q_pc[rd_ptr];
    end
    PCPlus4F = PCounterF + DATA_WIDTH'(4);
  end

  // Fetch PC, in-flight tracking, wrong-path kill flag and queue pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc         <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      kill        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (PCSrcE) begin
      fpc    <= PCTargetE & ~DATA_WIDTH'(3);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (outstanding) begin
        if (imem_rvalid) begin
          // The in-flight word lands now and is dropped here, so nothing is left to kill.
          outstanding <= 1'b0;
          kill        <= 1'b0;
        end else begin
          kill <= 1'b1;
        end
      end
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        req_pc      <= fpc;
        fpc         <= fpc + DATA_WIDTH'(4);
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp) begin
        kill <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful under count, so no reset needed.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_word[wr_ptr] <= imem_rdata;
    end
  end

endmodule
